// File: rtl/ed_mean_reader.sv
// Measurement controller for the error-distance accumulator: runs one round of ROUND samples,
// latches the sum, and divides it by ROUND with a bit-serial restoring divider.
module ed_mean_reader #(
    parameter int unsigned ROUND     = 102400,
    parameter int unsigned ACC_WIDTH = 148,
    parameter int unsigned CNT_WIDTH = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sample_valid,
    input  logic [ACC_WIDTH-1:0] acc_in,
    output logic                 acc_clr,
    output logic                 busy,
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [ACC_WIDTH-1:0] mean_out,
    output logic [CNT_WIDTH-1:0] rem_out,
    output logic [ACC_WIDTH-1:0] total_out
);

    localparam int unsigned          SW        = $clog2(ACC_WIDTH + 1);
    localparam logic [CNT_WIDTH:0]   DIVISOR   = (CNT_WIDTH + 1)'(ROUND);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(ROUND - 1);
    localparam logic [SW-1:0]        LAST_STEP = SW'(ACC_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_SETTLE,
        S_DIVIDE,
        S_HOLD
    } state_e;

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [SW-1:0]          step_q;
    logic [ACC_WIDTH-1:0]   dvd_q;
    logic [CNT_WIDTH-1:0]   part_q;
    logic                   acc_clr_q;
    logic                   busy_q;
    logic                   done_valid_q;
    logic [ACC_WIDTH-1:0]   mean_q;
    logic [CNT_WIDTH-1:0]   rem_q;
    logic [ACC_WIDTH-1:0]   total_q;

    logic [CNT_WIDTH:0]     shift_d;
    logic                   qbit_d;
    logic [CNT_WIDTH-1:0]   part_d;
    logic [ACC_WIDTH-1:0]   dvd_d;

    // The stored remainder is always < ROUND, so it fits CNT_WIDTH bits; only the
    // shifted value needs the extra bit. Quotient bits shift into the dividend register.
    always_comb begin
        shift_d = {part_q, dvd_q[ACC_WIDTH-1]};
        qbit_d  = (shift_d >= DIVISOR);
        part_d  = qbit_d ? CNT_WIDTH'(shift_d - DIVISOR) : CNT_WIDTH'(shift_d);
        dvd_d   = {dvd_q[ACC_WIDTH-2:0], qbit_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            step_q       <= '0;
            dvd_q        <= '0;
            part_q       <= '0;
            acc_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b0;
            mean_q       <= '0;
            rem_q        <= '0;
            total_q      <= '0;
        end else begin
            acc_clr_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_CLEAR;
                        acc_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q   <= '0;
                    state_q <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (sample_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    total_q <= acc_in;
                    dvd_q   <= acc_in;
                    part_q  <= '0;
                    step_q  <= '0;
                    state_q <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    dvd_q  <= dvd_d;
                    part_q <= part_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == LAST_STEP) begin
                        mean_q       <= dvd_d;
                        rem_q        <= part_d;
                        done_valid_q <= 1'b1;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (done_ready) begin
                        done_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign acc_clr    = acc_clr_q;
    assign busy       = busy_q;
    assign done_valid = done_valid_q;
    assign mean_out   = mean_q;
    assign rem_out    = rem_q;
    assign total_out  = total_q;

endmodule

// File: tb/tb_ed_mean_reader.sv
// Directed bench for ed_mean_reader with a small ED accumulator model (ROUND=4, 16-bit sums).
module tb_ed_mean_reader;

    localparam int unsigned ROUND = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          sample_valid = 1'b0;
    logic          done_ready = 1'b0;
    logic [AW-1:0] diff = '0;
    logic [AW-1:0] acc_q = '0;
    logic          acc_clr, busy, done_valid;
    logic [AW-1:0] mean_out, total_out;
    logic [CW-1:0] rem_out;

    int n_checks = 0;
    int n_fail   = 0;

    ed_mean_reader #(.ROUND(ROUND), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(rst_n), .start(start), .sample_valid(sample_valid),
        .acc_in(acc_q), .acc_clr(acc_clr), .busy(busy), .done_valid(done_valid),
        .done_ready(done_ready), .mean_out(mean_out), .rem_out(rem_out), .total_out(total_out)
    );

    always #5 clk = ~clk;

    // Accumulator: synchronous clear, sum visible the cycle after the sample
    always @(posedge clk) begin
        if (acc_clr) acc_q <= '0;
        else if (sample_valid) acc_q <= acc_q + diff;
    end

    task automatic start_meas();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if ({acc_clr, busy} !== 2'b11) begin
            n_fail++; $display("FAIL clear_state: acc_clr,busy=%b required 11", {acc_clr, busy});
        end
    endtask

    task automatic feed(input logic [AW-1:0] d0, d1, d2, d3, input logic [7:0] pat, input int unsigned plen);
        logic [AW-1:0] dv [4];
        int unsigned k;
        dv = '{d0, d1, d2, d3};
        k = 0;
        for (int unsigned i = 0; i < plen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (acc_clr !== 1'b0) begin
                    n_fail++; $display("FAIL clr_one_cycle: acc_clr=%b required 0", acc_clr);
                end
            end
            sample_valid = pat[i];
            diff = (pat[i] && k < 4) ? dv[k] : 16'hDEAD;
            if (pat[i]) k++;
        end
    endtask

    task automatic wait_done(output int unsigned lat);
        lat = 0;
        while (done_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            if (lat == 0) sample_valid = 1'b0;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk); done_ready = 1'b1;
        @(negedge clk); done_ready = 1'b0;
        n_checks++;
        if ({done_valid, busy} !== 2'b00) begin
            n_fail++; $display("FAIL handshake_idle: done_valid,busy=%b required 00", {done_valid, busy});
        end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({acc_clr, busy, done_valid, mean_out, rem_out, total_out} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: clr=%b busy=%b dv=%b mean=%0h rem=%0h total=%0h required all 0",
                               acc_clr, busy, done_valid, mean_out, rem_out, total_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic();
        int unsigned lat;
        start_meas();
        feed(16'd1, 16'd2, 16'd3, 16'd4, 8'h0F, 4);
        wait_done(lat);
        n_checks++;
        if (lat !== 18) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles required 18", lat);
        end
        n_checks++;
        if ({busy, total_out, mean_out, rem_out} !== {1'b1, 16'd10, 16'd2, 3'd2}) begin
            n_fail++; $display("FAIL basic_result: busy=%b total=%0d mean=%0d rem=%0d required 1/10/2/2",
                               busy, total_out, mean_out, rem_out);
        end
        handshake();
    endtask

    task automatic test_gaps();
        int unsigned lat;
        start_meas();
        feed(16'd1, 16'd2, 16'd3, 16'd4, 8'h59, 7);
        wait_done(lat);
        n_checks++;
        if (lat !== 18) begin
            n_fail++; $display("FAIL gaps_latency: got %0d cycles required 18", lat);
        end
        n_checks++;
        if ({total_out, mean_out, rem_out} !== {16'd10, 16'd2, 3'd2}) begin
            n_fail++; $display("FAIL gaps_result: total=%0d mean=%0d rem=%0d required 10/2/2",
                               total_out, mean_out, rem_out);
        end
        handshake();
    endtask

    task automatic test_max();
        int unsigned lat;
        start_meas();
        feed(16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF, 8'h0F, 4);
        wait_done(lat);
        n_checks++;
        if ({total_out, mean_out, rem_out} !== {16'hFFFC, 16'h3FFF, 3'd0}) begin
            n_fail++; $display("FAIL max_fffc: total=%0h mean=%0h rem=%0h required fffc/3fff/0",
                               total_out, mean_out, rem_out);
        end
        handshake();
        start_meas();
        feed(16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h4002, 8'h0F, 4);
        wait_done(lat);
        n_checks++;
        if ({total_out, mean_out, rem_out} !== {16'hFFFF, 16'h3FFF, 3'd3}) begin
            n_fail++; $display("FAIL max_ffff: total=%0h mean=%0h rem=%0h required ffff/3fff/3",
                               total_out, mean_out, rem_out);
        end
        handshake();
    endtask

    task automatic test_hold_stall();
        int unsigned lat;
        start_meas();
        feed(16'd9, 16'd0, 16'd0, 16'd0, 8'h0F, 4);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
            n_checks++;
            if ({done_valid, total_out, mean_out, rem_out} !== {1'b1, 16'd9, 16'd2, 3'd1}) begin
                n_fail++; $display("FAIL hold_stable: dv=%b total=%0d mean=%0d rem=%0d required 1/9/2/1",
                                   done_valid, total_out, mean_out, rem_out);
            end
        end
        start = 1'b0;
        handshake();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, acc_clr} !== 2'b00) begin
                n_fail++; $display("FAIL start_not_queued: busy,acc_clr=%b required 00", {busy, acc_clr});
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned lat;
        start_meas();
        feed(16'd1, 16'd1, 16'd1, 16'd1, 8'h0F, 4);
        @(negedge clk); sample_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({acc_clr, busy, done_valid, mean_out, rem_out, total_out} !== '0) begin
            n_fail++; $display("FAIL reset_mid_outputs: busy=%b dv=%b mean=%0h rem=%0h total=%0h required all 0",
                               busy, done_valid, mean_out, rem_out, total_out);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_mid_idle: busy,dv=%b required 00", {busy, done_valid});
        end
        start_meas();
        feed(16'd5, 16'd6, 16'd7, 16'd8, 8'h0F, 4);
        wait_done(lat);
        n_checks++;
        if ({total_out, mean_out, rem_out} !== {16'd26, 16'd6, 3'd2}) begin
            n_fail++; $display("FAIL reset_mid_rerun: total=%0d mean=%0d rem=%0d required 26/6/2",
                               total_out, mean_out, rem_out);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int unsigned lat;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        feed(16'd0, 16'd0, 16'd0, 16'd0, 8'h0F, 4);
        wait_done(lat);
        n_checks++;
        if ({done_valid, total_out, mean_out, rem_out} !== {1'b1, 16'd0, 16'd0, 3'd0}) begin
            n_fail++; $display("FAIL zero_result: dv=%b total=%0d mean=%0d rem=%0d required 1/0/0/0",
                               done_valid, total_out, mean_out, rem_out);
        end
        handshake();
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({acc_clr, busy} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_clear: acc_clr,busy=%b required 11", {acc_clr, busy});
        end
        feed(16'd2, 16'd2, 16'd2, 16'd3, 8'h0F, 4);
        wait_done(lat);
        n_checks++;
        if ({total_out, mean_out, rem_out} !== {16'd9, 16'd2, 3'd1}) begin
            n_fail++; $display("FAIL b2b_result: total=%0d mean=%0d rem=%0d required 9/2/1",
                               total_out, mean_out, rem_out);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_max();
        test_hold_stall();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
